// File: rtl/bitplane_transposer_if.sv
// rtl/bitplane_transposer_if.sv - packed-word input stream and MVU bank write port of the bit-plane transposer
interface bitplane_transposer_if #(
    parameter int XLEN         = 32,
    parameter int MVU_ADDR_LEN = 15,
    parameter int MVU_DATA_LEN = 64
);
    logic                    in_valid;
    logic                    in_ready;
    logic [XLEN-1:0]         in_data;
    logic                    mvu_wr_en;
    logic                    mvu_wr_grant;
    logic [MVU_ADDR_LEN-1:0] mvu_wr_addr;
    logic [MVU_DATA_LEN-1:0] mvu_wr_word;

    modport master (
        output in_valid, in_data, mvu_wr_grant,
        input  in_ready, mvu_wr_en, mvu_wr_addr, mvu_wr_word
    );

    modport slave (
        input  in_valid, in_data, mvu_wr_grant,
        output in_ready, mvu_wr_en, mvu_wr_addr, mvu_wr_word
    );
endinterface

// File: rtl/bitplane_transposer.sv
// rtl/bitplane_transposer.sv - unpacks runtime-precision elements into a block and writes it out as bit planes, MSB plane first
// Optional stall counter port: define TRANSPOSER_STALL_CNT_EN.
module bitplane_transposer #(
    parameter int NUM_WORDS     = 64,
    parameter int XLEN          = 32,
    parameter int MVU_ADDR_LEN  = 15,
    parameter int MVU_DATA_LEN  = 64,
    parameter int MAX_DATA_PREC = 16,
    parameter int LEN_W         = 24,
    localparam int PW           = $clog2(MAX_DATA_PREC) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
`ifdef TRANSPOSER_STALL_CNT_EN
    output logic [31:0]             stall_cnt,
`endif
    input  logic [PW-1:0]           cfg_prec,
    input  logic [MVU_ADDR_LEN-1:0] cfg_baddr,
    input  logic [LEN_W-1:0]        cfg_len,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    bitplane_transposer_if.slave    bus
);
    localparam int CW  = $clog2(NUM_WORDS + 1);
    localparam int PLW = (MAX_DATA_PREC > 1) ? $clog2(MAX_DATA_PREC) : 1;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN, S_DONE} state_t;

    state_t                  state, state_nxt;
    logic [PW-1:0]           prec_q;
    logic [PLW-1:0]          plog_q, cfg_plog, plane_q;
    logic [MVU_ADDR_LEN-1:0] addr_q;
    logic [LEN_W-1:0]        len_q, total_q, rem, epw, taken;
    logic [CW-1:0]           elem_q;
    logic                    err_q;
    logic                    prec_ok, in_fire, wr_fire, last_plane, blk_end;
    logic [MAX_DATA_PREC-1:0] blk_q    [NUM_WORDS];
    logic [MAX_DATA_PREC-1:0] slot_val [NUM_WORDS];
    logic [NUM_WORDS-1:0]    slot_we;
    logic [MVU_DATA_LEN-1:0] word_d;
    logic                    busy_d, done_d, ready_d, wr_en_d;

    assign prec_ok = (cfg_prec != '0) && ((cfg_prec & (cfg_prec - PW'(1))) == '0)
                     && (cfg_prec <= PW'(MAX_DATA_PREC));

    always_comb begin
        cfg_plog = '0;
        for (int i = 0; i < PW; i++)
            if (cfg_prec[i]) cfg_plog = PLW'(i);
    end

    // Final word of a transfer may carry more elements than remain; only the remainder is kept.
    assign in_fire    = (state == S_FILL) && bus.in_valid;
    assign wr_fire    = (state == S_DRAIN) && bus.mvu_wr_grant;
    assign last_plane = (plane_q == '0);
    assign rem        = len_q - total_q;
    assign epw        = LEN_W'(XLEN) >> plog_q;
    assign taken      = (rem < epw) ? rem : epw;
    assign blk_end    = ((int'(elem_q) + int'(taken)) >= NUM_WORDS) || ((total_q + taken) == len_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start && prec_ok) state_nxt = (cfg_len == '0) ? S_DONE : S_FILL;
            S_FILL:  if (in_fire && blk_end) state_nxt = S_DRAIN;
            S_DRAIN: if (wr_fire && last_plane) state_nxt = (total_q == len_q) ? S_DONE : S_FILL;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy_d  = (state != S_IDLE);
        done_d  = (state == S_DONE);
        ready_d = (state == S_FILL);
        wr_en_d = (state == S_DRAIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prec_q  <= '0;
            plog_q  <= '0;
            plane_q <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            total_q <= '0;
            elem_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= (state == S_IDLE) && start && !prec_ok;
            case (state)
                S_IDLE: if (start) begin
                    prec_q  <= cfg_prec;
                    plog_q  <= cfg_plog;
                    plane_q <= PLW'(cfg_prec - PW'(1));
                    addr_q  <= cfg_baddr;
                    len_q   <= cfg_len;
                    total_q <= '0;
                    elem_q  <= '0;
                end
                S_FILL: if (in_fire) begin
                    elem_q  <= elem_q + CW'(taken);
                    total_q <= total_q + taken;
                end
                S_DRAIN: if (wr_fire) begin
                    addr_q <= addr_q + MVU_ADDR_LEN'(1);
                    if (last_plane) begin
                        plane_q <= PLW'(prec_q - PW'(1));
                        elem_q  <= '0;
                    end else begin
                        plane_q <= plane_q - PLW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Slot j takes element (j - elem_q) of the current word.
    always_comb begin
        for (int j = 0; j < NUM_WORDS; j++) begin
            slot_we[j]  = 1'b0;
            slot_val[j] = '0;
            if (in_fire && (j >= int'(elem_q)) && ((j - int'(elem_q)) < int'(taken))) begin
                slot_we[j]  = 1'b1;
                slot_val[j] = MAX_DATA_PREC'(bus.in_data >> ((j - int'(elem_q)) << plog_q));
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int j = 0; j < NUM_WORDS; j++)
            if (slot_we[j]) blk_q[j] <= slot_val[j];
    end

    // Slots past elem_q hold stale data from an earlier block and are masked to zero.
    always_comb begin
        word_d = '0;
        for (int j = 0; j < NUM_WORDS; j++)
            word_d[j] = (j < int'(elem_q)) && blk_q[j][plane_q];
    end

`ifdef TRANSPOSER_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if ((state == S_IDLE) && start)
            stall_cnt <= '0;
        else if ((state == S_DRAIN) && !bus.mvu_wr_grant && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

    assign busy            = busy_d;
    assign done            = done_d;
    assign err             = err_q;
    assign bus.in_ready    = ready_d;
    assign bus.mvu_wr_en   = wr_en_d;
    assign bus.mvu_wr_addr = addr_q;
    assign bus.mvu_wr_word = word_d;
endmodule

// File: tb/tb_bitplane_transposer.sv
// tb/tb_bitplane_transposer.sv - scoreboard bench for bitplane_transposer with directed vectors
module tb_bitplane_transposer;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  cfg_prec;
    logic [14:0] cfg_baddr;
    logic [23:0] cfg_len;
    logic        start, busy, done, err;
`ifdef TRANSPOSER_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    bitplane_transposer_if #(.XLEN(32), .MVU_ADDR_LEN(15), .MVU_DATA_LEN(64)) bus ();

    bitplane_transposer #(
        .NUM_WORDS(64), .XLEN(32), .MVU_ADDR_LEN(15), .MVU_DATA_LEN(64),
        .MAX_DATA_PREC(16), .LEN_W(24)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef TRANSPOSER_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .cfg_prec  (cfg_prec),
        .cfg_baddr (cfg_baddr),
        .cfg_len   (cfg_len),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [14:0] addr;
        logic [63:0] word;
    } wr_t;

    wr_t exp_q[$];
    wr_t e;
    int  n_tests = 0;
    int  n_fail = 0;
    int  wr_cnt = 0;
    int  cyc = 0;
    int  last_wr_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic fail(input string name, input string msg);
        n_tests++;
        n_fail++;
        $display("FAIL %s: %s", name, msg);
    endtask

    task automatic push(input logic [14:0] a, input logic [63:0] w);
        wr_t t;
        t.addr = a;
        t.word = w;
        exp_q.push_back(t);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every completed write is popped against the scoreboard.
    always @(negedge clk) begin
        if (!rst && bus.mvu_wr_en && bus.mvu_wr_grant) begin
            check("ready_in_drain", 64'(bus.in_ready), 64'd0);
            if (exp_q.size() == 0) begin
                fail("unexpected_write", $sformatf("addr 0x%0h word 0x%0h with nothing expected",
                                                   bus.mvu_wr_addr, bus.mvu_wr_word));
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 64'(bus.mvu_wr_addr), 64'(e.addr));
                check("wr_word", bus.mvu_wr_word, e.word);
            end
            wr_cnt++;
            last_wr_cyc = cyc;
        end
    end

    task automatic do_start(input logic [4:0] p, input logic [14:0] a, input logic [23:0] l);
        @(posedge clk); #1;
        cfg_prec = p; cfg_baddr = a; cfg_len = l; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] d);
        int k = 0;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(negedge clk);
        while (!bus.in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!bus.in_ready) fail("send_timeout", "in_ready never rose");
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < 300);
        if (!done) begin
            fail(name, "done never pulsed");
        end else begin
            check({name, "_latency"}, 64'(cyc - last_wr_cyc), 64'd1);
            @(negedge clk);
            check({name, "_width"}, 64'(done), 64'd0);
            check({name, "_idle"}, 64'(busy), 64'd0);
        end
    endtask

    task automatic push_s1();
        push(15'h10, 64'h0);
        push(15'h11, 64'h0);
        push(15'h12, 64'hFFFF_FFFF_0000_0000);
        push(15'h13, 64'hFFFF_0000_FFFF_0000);
        push(15'h14, 64'hFF00_FF00_FF00_FF00);
        push(15'h15, 64'hF0F0_F0F0_F0F0_F0F0);
        push(15'h16, 64'hCCCC_CCCC_CCCC_CCCC);
        push(15'h17, 64'hAAAA_AAAA_AAAA_AAAA);
    endtask

    task automatic send_s1();
        for (int w = 0; w < 16; w++)
            send({8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        int k;
        rst = 1'b1; start = 1'b0; cfg_prec = '0; cfg_baddr = '0; cfg_len = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.mvu_wr_grant = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_wr_en", 64'(bus.mvu_wr_en), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_addr", 64'(bus.mvu_wr_addr), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // prec 8, element i = i
        push_s1();
        do_start(5'd8, 15'h10, 24'd64);
        send_s1();
        wait_done("s1_done");

        // prec 1, two blocks
        push(15'h20, 64'hFFFF_FFFF_FFFF_FFFF);
        push(15'h21, 64'h0);
        do_start(5'd1, 15'h20, 24'd128);
        send(32'hFFFF_FFFF);
        send(32'hFFFF_FFFF);
        send(32'h0);
        send(32'h0);
        wait_done("s2_done");

        // prec 4, partial block with address wrap
        push(15'h7FFE, 64'h0);
        push(15'h7FFF, 64'h3FF);
        push(15'h0000, 64'h3FF);
        push(15'h0001, 64'h3FF);
        do_start(5'd4, 15'h7FFE, 24'd10);
        send(32'h7777_7777);
        send(32'h7777_7777);
        wait_done("s3_done");

        // back-pressure on the first write
        push(15'h40, 64'hCCCC);
        push(15'h41, 64'hAAAA);
        do_start(5'd2, 15'h40, 24'd16);
        bus.mvu_wr_grant = 1'b0;
        send(32'hE4E4_E4E4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_wr_en", 64'(bus.mvu_wr_en), 64'd1);
            check("bp_addr", 64'(bus.mvu_wr_addr), 64'h40);
            check("bp_word", bus.mvu_wr_word, 64'hCCCC);
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
        end
        @(posedge clk); #1;
        bus.mvu_wr_grant = 1'b1;
        wait_done("bp_done");
`ifdef TRANSPOSER_STALL_CNT_EN
        check("stall_cnt", 64'(stall_cnt), 64'd5);
`endif

        // illegal precision
        do_start(5'd3, 15'h10, 24'd64);
        @(negedge clk);
        check("illegal_err_hi", 64'(err), 64'd1);
        check("illegal_busy0", 64'(busy), 64'd0);
        @(negedge clk);
        check("illegal_err_lo", 64'(err), 64'd0);
        check("illegal_busy1", 64'(busy), 64'd0);
        check("illegal_wr_en", 64'(bus.mvu_wr_en), 64'd0);

        // zero-length transfer
        do_start(5'd8, 15'h10, 24'd0);
        @(negedge clk);
        check("len0_done_hi", 64'(done), 64'd1);
        @(negedge clk);
        check("len0_done_lo", 64'(done), 64'd0);
        check("len0_busy", 64'(busy), 64'd0);

        // reset after the third write of an 8-plane drain
        push_s1();
        base = wr_cnt;
        do_start(5'd8, 15'h10, 24'd64);
        send_s1();
        k = 0;
        while (wr_cnt < base + 3 && k < 300) begin
            @(posedge clk);
            k++;
        end
        if (wr_cnt < base + 3) fail("rst_mid_wait", "third write never seen");
        #1;
        rst = 1'b1;
        #1;
        check("midrst_wr_en", 64'(bus.mvu_wr_en), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd0);
        check("midrst_writes", 64'(wr_cnt - base), 64'd3);
        exp_q.delete();
        repeat (2) @(negedge clk);
        check("midrst_no_write", 64'(wr_cnt - base), 64'd3);
        @(posedge clk); #1;
        rst = 1'b0;

        push_s1();
        do_start(5'd8, 15'h10, 24'd64);
        send_s1();
        wait_done("s1_rerun_done");

        repeat (3) @(negedge clk);
        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bitplane_transposer.md
Name: bitplane_transposer

Overview:
- Runtime-precision successor to the MVU data transposer.
- Accepts packed XLEN-bit input words over a valid/ready handshake and unpacks XLEN/prec elements per word into a NUM_WORDS-element buffer.
- When the buffer is full or the transfer ends, writes prec bit-plane words into MVU RAM.
- Sits between the controller/DMA write path and one MVU data bank write port. Adds write-grant back-pressure, partial-block padding and transfer-length control.

Parameters:
- NUM_WORDS, 64: elements per block = bits per MVU word; must be a multiple of XLEN.
- XLEN, 32: input word width.
- MVU_ADDR_LEN, 15: MVU bank address width.
- MVU_DATA_LEN, 64: MVU bank word width; must equal NUM_WORDS.
- MAX_DATA_PREC, 16: largest legal precision (power of two, <= XLEN).
- LEN_W, 24: width of the element-count field.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cfg_prec  in  $clog2(MAX_DATA_PREC)+1  element precision; legal values are 1, 2, 4, 8, 16, capped by MAX_DATA_PREC
- cfg_baddr  in  MVU_ADDR_LEN  base write address
- cfg_len  in  LEN_W  total elements in the transfer
- start  in  1  one-cycle pulse; sampled only in IDLE
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse at end of transfer
- err  out  1  one-cycle pulse on illegal cfg_prec
- in_valid  in  1  input word valid
- in_ready  out  1  input word accepted
- in_data  in  XLEN  packed elements; element k = in_data[k*prec +: prec]
- mvu_wr_en  out  1  write request
- mvu_wr_grant  in  1  a write completes when mvu_wr_en && mvu_wr_grant
- mvu_wr_addr  out  MVU_ADDR_LEN  write address
- mvu_wr_word  out  MVU_DATA_LEN  bit plane; bit j = bit p of buffered element j

Behaviour:
- Reset: all outputs are 0, state is IDLE, all counters are 0. Buffer contents are don't-care. Reset takes effect immediately, including mid-FILL or mid-DRAIN; nothing is written after rst rises.

- IDLE:
  - On start, capture cfg_prec, cfg_baddr and cfg_len into registers.
  - Illegal prec: err pulses the next cycle, state stays IDLE, no writes.
  - cfg_len = 0: go to DONE.
  - Otherwise: go to FILL.
  - start is ignored while busy.

- FILL:
  - in_ready = 1.
  - Each handshake stores XLEN/prec elements at buffer[elem_cnt ...], LSB element first, and elem_cnt and total_cnt advance.
  - Elements beyond cfg_len in the final word are discarded.
  - When the block is full (NUM_WORDS elements) or total_cnt reaches cfg_len, go to DRAIN on the next cycle. Unfilled slots read as 0.

- DRAIN:
  - in_ready = 0.
  - mvu_wr_en = 1 from the first DRAIN cycle.
  - Planes are issued MSB first: plane prec-1 goes to the current address, plane 0 goes last.
  - Plane index and address advance only on a completed write. Addr, word and en stay stable while grant is low.
  - Address increments by 1 per write and wraps modulo 2^MVU_ADDR_LEN.
  - After plane 0 completes: go to DONE if total_cnt == cfg_len, otherwise clear elem_cnt and return to FILL.
  - The address continues from the next location, so block k starts at baddr + k*prec.

- DONE: done = 1 for one cycle, then IDLE.

- Latency:
  - Block-completing handshake at cycle t: first mvu_wr_en at t+1.
  - With grant held high, the last write is at t+prec.
  - done is high at t+prec+1.

- Outputs are registered or decoded from registered state only; no combinational path from in_valid or grant.

Optional Feature:
- Macro: TRANSPOSER_STALL_CNT_EN.
- Defined: adds output port stall_cnt [31:0]. It counts cycles with mvu_wr_en && !mvu_wr_grant, clears on an accepted start, saturates at all-ones, and resets to 0.
- Undefined: the port and counter do not exist; behaviour is otherwise identical.

Test Plan:
- prec=8, len=64, baddr=0x10, 16 words with element i = i, grant tied 1 -> 8 writes to 0x10..0x17. 0x10 (plane 7) = 0. 0x16 (plane 1) = 0xCCCC_CCCC_CCCC_CCCC. 0x17 (plane 0) = 0xAAAA_AAAA_AAAA_AAAA. done pulses one cycle after the 0x17 write.
- prec=1, len=128, words 0xFFFF_FFFF ×2 then 0x0 ×2 -> baddr gets all-ones, baddr+1 gets 0. in_ready low during each DRAIN; FILL resumes afterwards.
- prec=4, len=10, baddr=0x7FFE, two words 0x7777_7777 -> 4 writes:
  - addr 0x7FFE = 0x0
  - addr 0x7FFF = 0x3FF
  - addr 0x0000 = 0x3FF
  - addr 0x0001 = 0x3FF
  Upper elements are zero-padded and the address wraps.
- Back-pressure: grant low for 5 cycles at the first DRAIN write -> mvu_wr_en, addr and word held constant, in_ready = 0, no lost write. With macro defined: stall_cnt = 5.
- Illegal prec: start with cfg_prec=3 -> err high exactly one cycle, busy stays 0, mvu_wr_en never asserts. cfg_len=0 -> done after one cycle, no writes.
- Reset mid-op: rst after the 3rd write of an 8-plane drain -> mvu_wr_en, busy and in_ready all 0 immediately. A new start then repeats the first scenario correctly.
